// File: rtl/i2s_rx_fifo.sv
// ============================================================================
// i2s_rx_fifo
// ----------------------------------------------------------------------------
// I2S serial-audio receiver with an output queue.
//
// SD is deserialised MSB-first under WS channel framing into one word per
// channel slot. A word may have any length: the first DATA_W bits are kept,
// and any further bits are dropped with the word's trunc flag raised. Each
// word is closed by a WS change or by in_valid dropping low. The closed
// record {data, chan, len, trunc} goes into a show-ahead FIFO. The FIFO is
// read through a valid/ready handshake and reports dropped records through
// a sticky overflow flag.
//
// Optional build macro:
//   I2S_RX_SIGNEXT_EN - when defined, words shorter than DATA_W are
//                       sign-extended from bit len-1. Otherwise they are
//                       zero-extended.
//
// Parameters:
//   DATA_W      maximum stored sample width (>= 2)
//   FIFO_DEPTH  queue entries (power of two, >= 2)
//   LEN_W       width of the length field (derived)
//   LVL_W       width of the occupancy output (derived)
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-high reset, clears all state
//   in_valid   in   qualifies SD/WS this cycle
//   SD         in   serial data, MSB first
//   WS         in   word select, 0 = left, 1 = right
//   out_ready  in   consumer accepts the head entry
//   clr_ovf    in   clears the sticky overflow flag
//   out_valid  out  FIFO head is valid
//   out_data   out  head sample, right-aligned (0 when empty)
//   out_chan   out  head channel (0 when empty)
//   out_len    out  head bit count, 1..DATA_W (0 when empty)
//   out_trunc  out  head word had more than DATA_W bits (0 when empty)
//   ovf        out  sticky: a completed word was dropped
//   level      out  current FIFO occupancy, 0..FIFO_DEPTH
// ============================================================================
module i2s_rx_fifo #(
    parameter  int DATA_W     = 32,
    parameter  int FIFO_DEPTH = 4,
    localparam int LEN_W      = $clog2(DATA_W + 1),
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              SD,
    input  logic              WS,
    input  logic              out_ready,
    input  logic              clr_ovf,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_chan,
    output logic [LEN_W-1:0]  out_len,
    output logic              out_trunc,
    output logic              ovf,
    output logic [LVL_W-1:0]  level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    // Receiver states. The channel of the word being assembled is encoded
    // by the state itself, so no separate channel register is needed.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_nextState;

    // Word assembly
    logic [DATA_W-1:0] r_shiftReg;
    logic [LEN_W-1:0]  r_bitCnt;
    logic              r_trunc;

    // FSM control strobes
    logic w_push;
    logic w_start;
    logic w_append;
    logic w_curChan;

    // Record being pushed
    logic [DATA_W-1:0] w_pushData;

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0] r_memData  [FIFO_DEPTH];
    logic              r_memChan  [FIFO_DEPTH];
    logic [LEN_W-1:0]  r_memLen   [FIFO_DEPTH];
    logic              r_memTrunc [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [LVL_W-1:0]  r_count;
    logic              r_ovf;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_accept;
    logic w_drop;

    assign w_curChan = (r_state == ST_RIGHT);

    // State register. Reset discards any partial word by returning to
    // IDLE, so nothing is pushed for it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and control decode. A word closes when the stream pauses
    // or when WS flips. On a flip, the bit sampled in the same cycle is
    // already the first bit of the new word, so close and start coincide.
    always_comb begin
        w_nextState = r_state;
        w_push      = 1'b0;
        w_start     = 1'b0;
        w_append    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_start     = 1'b1;
                    w_nextState = WS ? ST_RIGHT : ST_LEFT;
                end
            end
            ST_LEFT, ST_RIGHT: begin
                if (!in_valid) begin
                    w_push      = 1'b1;
                    w_nextState = ST_IDLE;
                end else if (WS != w_curChan) begin
                    w_push      = 1'b1;
                    w_start     = 1'b1;
                    w_nextState = WS ? ST_RIGHT : ST_LEFT;
                end else begin
                    w_append    = 1'b1;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Shift register and bit counter. Bits enter at the LSB, so the stored
    // word is right-aligned. Once DATA_W bits are held, the counter stops
    // and later bits only mark the word as truncated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shiftReg <= '0;
            r_bitCnt   <= '0;
            r_trunc    <= 1'b0;
        end else if (w_start) begin
            r_shiftReg <= {{(DATA_W-1){1'b0}}, SD};
            r_bitCnt   <= LEN_W'(1);
            r_trunc    <= 1'b0;
        end else if (w_append) begin
            if (r_bitCnt < LEN_W'(DATA_W)) begin
                r_shiftReg <= {r_shiftReg[DATA_W-2:0], SD};
                r_bitCnt   <= r_bitCnt + LEN_W'(1);
            end else begin
                r_trunc    <= 1'b1;
            end
        end
    end

`ifdef I2S_RX_SIGNEXT_EN
    logic w_signBit;

    // Extension of short words. The sign bit is the MSB of the received
    // word, at position len-1. Every stored bit above it takes its value.
    // A full-length word has no bits above len-1, so it passes unchanged.
    always_comb begin
        w_pushData = r_shiftReg;
        w_signBit  = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (LEN_W'(i) == (r_bitCnt - LEN_W'(1))) begin
                w_signBit = r_shiftReg[i];
            end
        end
        for (int i = 0; i < DATA_W; i++) begin
            if (LEN_W'(i) >= r_bitCnt) begin
                w_pushData[i] = w_signBit;
            end
        end
    end
`else
    // Extension of short words. The upper bits of the shift register are
    // already zero, so zero-extension needs no extra logic.
    always_comb begin
        w_pushData = r_shiftReg;
    end
`endif

    // FIFO handshake decode. A pop on a full FIFO frees a slot in the same
    // edge, so a push that coincides with it is still accepted.
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == LVL_W'(FIFO_DEPTH));
    assign w_pop    = !w_empty && out_ready;
    assign w_accept = w_push && (!w_full || w_pop);
    assign w_drop   = w_push && w_full && !w_pop;

    // Storage write. The entries have no reset because every read of them
    // is gated by out_valid, so their power-up contents are never visible.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_memData[r_wrPtr]  <= w_pushData;
            r_memChan[r_wrPtr]  <= w_curChan;
            r_memLen[r_wrPtr]   <= r_bitCnt;
            r_memTrunc[r_wrPtr] <= r_trunc;
        end
    end

    // Pointers and occupancy. Depth is a power of two, so the pointers
    // wrap on their own. The occupancy counter keeps level exact over the
    // full 0..FIFO_DEPTH range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + LVL_W'(1);
                2'b01:   r_count <= r_count - LVL_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow. A drop in the same cycle as a clear takes priority,
    // so that event is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    // Show-ahead outputs. Each field reads 0 while the queue is empty.
    assign out_valid = !w_empty;
    assign out_data  = out_valid ? r_memData[r_rdPtr]  : '0;
    assign out_chan  = out_valid ? r_memChan[r_rdPtr]  : 1'b0;
    assign out_len   = out_valid ? r_memLen[r_rdPtr]   : '0;
    assign out_trunc = out_valid ? r_memTrunc[r_rdPtr] : 1'b0;
    assign ovf       = r_ovf;
    assign level     = r_count;

endmodule

// File: tb/tb_i2s_rx_fifo.sv
// ============================================================================
// tb_i2s_rx_fifo
// ----------------------------------------------------------------------------
// Self-checking bench for i2s_rx_fifo with the default parameters.
// The reference model works at the level of whole words:
//  - it accumulates the bits of the current word;
//  - it closes the word when the channel changes or the stream pauses;
//  - it converts the word to the expected record with plain arithmetic;
//  - it keeps a queue that holds the expected FIFO contents.
// ============================================================================
module tb_i2s_rx_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DW + 1);
    localparam int LVLW  = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [DW-1:0] data;
        logic          chan;
        logic [LW-1:0] len;
        logic          trunc;
    } rec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            SD;
    logic            WS;
    logic            out_ready;
    logic            clr_ovf;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_chan;
    logic [LW-1:0]   out_len;
    logic            out_trunc;
    logic            ovf;
    logic [LVLW-1:0] level;

    // Reference model state
    rec_t        expQ[$];
    logic        expOvf;
    logic        pendValid;
    logic        pendChan;
    logic [63:0] pendBits;
    int          pendN;
    logic        outReady;

    int nCompared = 0;
    int nMismatch = 0;

    i2s_rx_fifo #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .SD        (SD),
        .WS        (WS),
        .out_ready (out_ready),
        .clr_ovf   (clr_ovf),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_len   (out_len),
        .out_trunc (out_trunc),
        .ovf       (ovf),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatch++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected record for a finished word of n bits (bits right-aligned in pendBits)
    task automatic modelClose();
        rec_t        r;
        logic [63:0] wide;
        int          len;
        if (pendN > DW) begin
            wide    = pendBits >> (pendN - DW);
            len     = DW;
            r.trunc = 1'b1;
        end else begin
            wide    = pendBits;
            len     = pendN;
            r.trunc = 1'b0;
        end
`ifdef I2S_RX_SIGNEXT_EN
        if (len < DW && ((wide >> (len - 1)) & 64'd1) == 64'd1) begin
            wide = wide | ~((64'd1 << len) - 64'd1);
        end
`endif
        r.data = wide[DW-1:0];
        r.chan = pendChan;
        r.len  = LW'(len);
        if (expQ.size() < DEPTH) begin
            expQ.push_back(r);
        end else begin
            expOvf = 1'b1;
        end
        pendValid = 1'b0;
    endtask

    task automatic checkOutput();
        rec_t h;
        logic ev;
        ev = (expQ.size() > 0);
        h  = ev ? expQ[0] : '0;
        checkEq("out_valid", out_valid, ev);
        checkEq("out_data",  out_data,  h.data);
        checkEq("out_chan",  out_chan,  h.chan);
        checkEq("out_len",   out_len,   h.len);
        checkEq("out_trunc", out_trunc, h.trunc);
        checkEq("level",     level,     64'(expQ.size()));
        checkEq("ovf",       ovf,       expOvf);
    endtask

    // One clock of stimulus. The model applies the same edge first: the pop
    // happens before the push, then the clear, then any drop.
    task automatic applyStimulus(input logic valid, input logic ws, input logic sd, input logic clr);
        if (outReady && expQ.size() > 0) void'(expQ.pop_front());
        if (clr) expOvf = 1'b0;
        if (pendValid && (!valid || ws != pendChan)) modelClose();
        if (valid) begin
            if (!pendValid) begin
                pendValid = 1'b1;
                pendChan  = ws;
                pendBits  = '0;
                pendN     = 0;
            end
            pendBits = {pendBits[62:0], sd};
            pendN++;
        end
        in_valid  = valid;
        WS        = ws;
        SD        = sd;
        clr_ovf   = clr;
        out_ready = outReady;
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic sendWord(input logic ws, input logic [63:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) applyStimulus(1'b1, ws, val[i], 1'b0);
    endtask

    task automatic idleCycle(input logic clr);
        applyStimulus(1'b0, 1'($urandom), 1'($urandom), clr);
    endtask

    task automatic drainAll();
        outReady = 1'b1;
        for (int g = 0; g < DEPTH + 2; g++) begin
            if (expQ.size() > 0) idleCycle(1'b0);
        end
        outReady = 1'b0;
        idleCycle(1'b0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        clr_ovf = 1'b0;
        outReady = 1'b0;
        @(posedge clk);
        #1;
        expQ.delete();
        expOvf = 1'b0;
        pendValid = 1'b0;
        pendN = 0;
        pendChan = 1'b0;
        pendBits = '0;
        checkOutput();
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic sendFive8();
        for (int w = 0; w < 5; w++) sendWord(1'(w % 2), 64'($urandom_range(0, 255)), 8);
    endtask

    initial begin
        SD = 1'b0;
        WS = 1'b0;
        doReset();

        $display("[TB] stereo 32-bit words");
        sendWord(1'b0, 64'hDEADBEEF, 32);
        sendWord(1'b1, 64'h12345678, 32);
        idleCycle(1'b0);
        drainAll();

        $display("[TB] short 24-bit word");
        sendWord(1'b0, 64'h800001, 24);
        sendWord(1'b1, 64'h5A, 8);
        idleCycle(1'b0);
        drainAll();

        $display("[TB] long 40-bit word");
        sendWord(1'b1, 64'hAABBCCDD11, 40);
        idleCycle(1'b0);
        drainAll();

        $display("[TB] overflow and clear");
        sendFive8();
        idleCycle(1'b0);
        drainAll();
        idleCycle(1'b1);
        sendFive8();
        idleCycle(1'b1);
        drainAll();
        idleCycle(1'b1);

        $display("[TB] full with simultaneous push and pop");
        sendFive8();
        outReady = 1'b1;
        idleCycle(1'b0);
        outReady = 1'b0;
        drainAll();

        $display("[TB] back-to-back 1-bit words");
        outReady = 1'b1;
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'(i % 2), 1'($urandom), 1'b0);
        idleCycle(1'b0);
        drainAll();

        $display("[TB] randomized words");
        for (int r = 0; r < 8; r++) begin
            logic ch;
            ch = 1'($urandom);
            for (int w = 0; w < int'($urandom_range(1, 6)); w++) begin
                int          n;
                logic [63:0] v;
                n        = $urandom_range(1, 40);
                v        = {$urandom, $urandom};
                v        = v & ((64'd1 << n) - 64'd1);
                outReady = 1'($urandom);
                sendWord(ch, v, n);
                ch = ~ch;
            end
            outReady = 1'b0;
            idleCycle(1'($urandom));
            drainAll();
            idleCycle(1'b1);
        end

        $display("[TB] reset mid-word");
        sendWord(1'b0, 64'h2AB, 10);
        rst = 1'b1;
        #2;
        expQ.delete();
        expOvf = 1'b0;
        pendValid = 1'b0;
        checkOutput();
        doReset();
        sendWord(1'b1, 64'hBEEF, 16);
        idleCycle(1'b0);
        drainAll();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
